// File: rtl/wt_mem_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wt_mem_req_arbiter                                               |
// | Purpose  : Shares the write-through cached memory port between icache,     |
// |            dcache load and write buffer; allocates TIDs, keeps RAW line    |
// |            ordering and routes responses back by TID.                      |
// | Options  : WT_ARB_PERF_CNT_EN adds per-port grant and stall counters.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wt_mem_req_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int TID_W      = 2,
  parameter int LINE_OFF_W = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic                      mem_req_valid_o,
  input  logic                      mem_req_ready_i,
  output logic [ADDR_W-1:0]         mem_req_addr_o,
  output logic                      mem_req_we_o,
  output logic [DATA_W-1:0]         mem_req_wdata_o,
  output logic [TID_W-1:0]          mem_req_tid_o,
  input  logic                      mem_rsp_valid_i,
  input  logic [TID_W-1:0]          mem_rsp_tid_i,
  input  logic [DATA_W-1:0]         mem_rsp_data_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic                      busy_o,
`ifdef WT_ARB_PERF_CNT_EN
  output logic [NUM_REQ*32-1:0]     perf_grant_o,
  output logic [31:0]               perf_stall_o,
`endif
  output logic                      proto_err_o
);

  localparam int DEPTH  = 2**TID_W;
  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LINE_W = ADDR_W - LINE_OFF_W;

  logic [DEPTH-1:0]  r_in_use;
  logic [DEPTH-1:0]  r_we;
  logic [SRC_W-1:0]  r_src  [DEPTH];
  logic [LINE_W-1:0] r_line [DEPTH];
  logic [SRC_W-1:0]  r_rr_ptr;
  logic              r_proto_err;

  logic              w_rsp_hit;
  logic              w_rsp_err;
  logic              w_slot_free;
  logic              w_free_found;
  logic [TID_W-1:0]  w_free_tid;
  logic [NUM_REQ-1:0] w_hazard;
  logic [NUM_REQ-1:0] w_elig;
  logic              w_grant;
  logic [SRC_W-1:0]  w_grant_idx;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_we;

  function automatic logic [SRC_W-1:0] rr_index(input logic [SRC_W-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return SRC_W'(s);
  endfunction

  assign w_rsp_hit   = mem_rsp_valid_i && r_in_use[mem_rsp_tid_i];
  assign w_rsp_err   = mem_rsp_valid_i && !r_in_use[mem_rsp_tid_i];
  assign w_slot_free = !mem_req_valid_o || mem_req_ready_i;

  // Allocation looks only at registered state, so a TID freed this cycle is not reused yet.
  always_comb begin
    w_free_found = 1'b0;
    w_free_tid   = '0;
    for (int t = 0; t < DEPTH; t++) begin
      if (!w_free_found && !r_in_use[t]) begin
        w_free_found = 1'b1;
        w_free_tid   = TID_W'(t);
      end
    end
  end

  // A write whose response arrives this cycle no longer blocks a read to its line.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_hazard[i] = 1'b0;
      for (int t = 0; t < DEPTH; t++) begin
        if (r_in_use[t] && r_we[t] &&
            (r_line[t] == req_addr_i[i*ADDR_W+LINE_OFF_W +: LINE_W]) &&
            !(w_rsp_hit && (mem_rsp_tid_i == TID_W'(t))))
          w_hazard[i] = 1'b1;
      end
      w_elig[i] = req_valid_i[i] && w_free_found && w_slot_free &&
                  (req_we_i[i] || !w_hazard[i]);
    end
  end

  always_comb begin
    w_grant     = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_grant && w_elig[rr_index(r_rr_ptr, k)]) begin
        w_grant     = 1'b1;
        w_grant_idx = rr_index(r_rr_ptr, k);
      end
    end
  end

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = w_grant && (w_grant_idx == SRC_W'(i));
      rsp_valid_o[i] = w_rsp_hit && (r_src[mem_rsp_tid_i] == SRC_W'(i));
      if (w_grant_idx == SRC_W'(i)) begin
        w_sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata_i[i*DATA_W +: DATA_W];
        w_sel_we    = req_we_i[i];
      end
    end
  end

  assign rsp_data_o  = mem_rsp_data_i;
  assign busy_o      = (|r_in_use) || mem_req_valid_o;
  assign proto_err_o = r_proto_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_in_use    <= '0;
      r_we        <= '0;
      r_rr_ptr    <= '0;
      r_proto_err <= 1'b0;
      for (int t = 0; t < DEPTH; t++) begin
        r_src[t]  <= '0;
        r_line[t] <= '0;
      end
    end else begin
      if (w_rsp_hit) r_in_use[mem_rsp_tid_i] <= 1'b0;
      if (w_rsp_err) r_proto_err <= 1'b1;
      if (w_grant) begin
        r_in_use[w_free_tid] <= 1'b1;
        r_we[w_free_tid]     <= w_sel_we;
        r_src[w_free_tid]    <= w_grant_idx;
        r_line[w_free_tid]   <= w_sel_addr[ADDR_W-1:LINE_OFF_W];
        r_rr_ptr             <= rr_index(w_grant_idx, 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
      mem_req_we_o    <= 1'b0;
      mem_req_wdata_o <= '0;
      mem_req_tid_o   <= '0;
    end else if (w_grant) begin
      mem_req_valid_o <= 1'b1;
      mem_req_addr_o  <= w_sel_addr;
      mem_req_we_o    <= w_sel_we;
      mem_req_wdata_o <= w_sel_wdata;
      mem_req_tid_o   <= w_free_tid;
    end else if (mem_req_ready_i) begin
      mem_req_valid_o <= 1'b0;
    end
  end

`ifdef WT_ARB_PERF_CNT_EN
  logic [31:0] r_perf_grant [NUM_REQ];
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_stall <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_perf_grant[i] <= '0;
    end else begin
      if (w_grant) r_perf_grant[w_grant_idx] <= r_perf_grant[w_grant_idx] + 32'd1;
      if ((|req_valid_i) && !w_grant) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf_out
    assign perf_grant_o[g*32 +: 32] = r_perf_grant[g];
  end
  assign perf_stall_o = r_perf_stall;
`endif

endmodule
`default_nettype wire
